// File: rtl/regfile_pkg.sv
// Shared constants and types for the regfile_sb register file.
// The stack-pointer reset value is built from PC_INIT and MEM_DEPTH when the build supplies them.
`ifndef PC_INIT
`define PC_INIT 32'h8000_0000
`endif
`ifndef MEM_DEPTH
`define MEM_DEPTH 32'h0001_0000
`endif

package regfile_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned NREG_DEFAULT = 32;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_SP   = 2;

    localparam logic [31:0] SP_INIT_DEFAULT = `PC_INIT + `MEM_DEPTH;

    typedef logic [$clog2(NREG_DEFAULT)-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Load-pending scoreboard: one busy bit per register, a pending counter and
// single-cycle error pulses for illegal issue / writeback traffic.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEFAULT,
    localparam int unsigned AW  = $clog2(NREG)
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            iss_en_i,
    input  logic [AW-1:0]   iss_addr_i,
    input  logic            wb_en_i,
    input  logic [AW-1:0]   wb_addr_i,
    output logic [NREG-1:0] busy_o,
    output logic [AW:0]     pend_cnt_o,
    output logic            err_o
);

    logic [NREG-1:0] busy_d, busy_q;
    logic [AW:0]     cnt_d, cnt_q;
    logic            iss_v, wb_v, same, inc, dec;

    assign iss_v = iss_en_i && (iss_addr_i != AW'(REG_ZERO));
    assign wb_v  = wb_en_i && (wb_addr_i != AW'(REG_ZERO));
    assign same  = iss_v && wb_v && (iss_addr_i == wb_addr_i);

    // A same-cycle reissue supersedes the returning load, so the bit stays set.
    always_comb begin
        busy_d = busy_q;
        if (wb_v) begin
            busy_d[wb_addr_i] = 1'b0;
        end
        if (iss_v && (!busy_q[iss_addr_i] || same)) begin
            busy_d[iss_addr_i] = 1'b1;
        end
    end

    assign inc = iss_v && !busy_q[iss_addr_i];
    assign dec = wb_v && busy_q[wb_addr_i] && !same;

    always_comb begin
        cnt_d = cnt_q;
        case ({inc, dec})
            2'b10:   cnt_d = cnt_q + {{AW{1'b0}}, 1'b1};
            2'b01:   cnt_d = cnt_q - {{AW{1'b0}}, 1'b1};
            default: cnt_d = cnt_q;
        endcase
    end

    assign err_o = (iss_v && busy_q[iss_addr_i] && !same) || (wb_v && !busy_q[wb_addr_i]);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-write-port integer register file with load scoreboard.
// Defining REGFILE_BYPASS_EN forwards same-cycle writes and load returns to the read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned      XLEN    = XLEN_DEFAULT,
    parameter int unsigned      NREG    = NREG_DEFAULT,
    parameter logic [XLEN-1:0]  SP_INIT = XLEN'(SP_INIT_DEFAULT),
    localparam int unsigned     AW      = $clog2(NREG)
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic [AW-1:0]   rs1_addr_i,
    input  logic [AW-1:0]   rs2_addr_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic            rs1_busy_o,
    output logic            rs2_busy_o,
    input  logic            wa_en_i,
    input  logic [AW-1:0]   wa_addr_i,
    input  logic [XLEN-1:0] wa_data_i,
    input  logic            wb_en_i,
    input  logic [AW-1:0]   wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            iss_en_i,
    input  logic [AW-1:0]   iss_addr_i,
    output logic [AW:0]     pend_cnt_o,
    output logic            err_o
);

    logic [XLEN-1:0] mem_d [NREG];
    logic [XLEN-1:0] mem_q [NREG];
    logic [NREG-1:0] busy;
    logic            sb_err, wa_v, wb_v, collide, waw;
    logic            err_d, err_q;

    assign wa_v    = wa_en_i && (wa_addr_i != AW'(REG_ZERO));
    assign wb_v    = wb_en_i && (wb_addr_i != AW'(REG_ZERO));
    assign collide = wa_v && wb_v && (wa_addr_i == wb_addr_i);
    assign waw     = wa_v && busy[wa_addr_i];

    regfile_scoreboard #(
        .NREG (NREG)
    ) u_sb (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .iss_en_i   (iss_en_i),
        .iss_addr_i (iss_addr_i),
        .wb_en_i    (wb_en_i),
        .wb_addr_i  (wb_addr_i),
        .busy_o     (busy),
        .pend_cnt_o (pend_cnt_o),
        .err_o      (sb_err)
    );

    // Port B is applied last so it wins a same-register collision.
    always_comb begin
        mem_d = mem_q;
        if (wa_v) begin
            mem_d[wa_addr_i] = wa_data_i;
        end
        if (wb_v) begin
            mem_d[wb_addr_i] = wb_data_i;
        end
    end

    assign err_d = err_q | sb_err | collide | waw;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem_q[i] <= (i == REG_SP) ? SP_INIT : '0;
            end
            err_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

    logic [AW-1:0]   rs_addr [2];
    logic [XLEN-1:0] rs_data [2];
    logic            rs_busy [2];

    assign rs_addr[0] = rs1_addr_i;
    assign rs_addr[1] = rs2_addr_i;

`ifdef REGFILE_BYPASS_EN
    logic iss_v;
    assign iss_v = iss_en_i && (iss_addr_i != AW'(REG_ZERO));
`endif

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rs_data[p] = mem_q[rs_addr[p]];
            rs_busy[p] = busy[rs_addr[p]];
`ifdef REGFILE_BYPASS_EN
            if (wa_v && (wa_addr_i == rs_addr[p])) begin
                rs_data[p] = wa_data_i;
            end
            if (wb_v && (wb_addr_i == rs_addr[p])) begin
                rs_data[p] = wb_data_i;
                // A same-cycle reissue keeps the register pending.
                if (!(iss_v && (iss_addr_i == rs_addr[p]))) begin
                    rs_busy[p] = 1'b0;
                end
            end
`endif
            if (rs_addr[p] == AW'(REG_ZERO)) begin
                rs_data[p] = '0;
                rs_busy[p] = 1'b0;
            end
        end
    end

    assign rs1_data_o = rs_data[0];
    assign rs2_data_o = rs_data[1];
    assign rs1_busy_o = rs_busy[0];
    assign rs2_busy_o = rs_busy[1];

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, a full-scoreboard
// fill/drain sequence and random traffic against an array-based reference model.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam logic [31:0] SP   = SP_INIT_DEFAULT;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   rs1_addr, rs2_addr, wa_addr, wb_addr, iss_addr;
    logic [XLEN-1:0] rs1_data, rs2_data, wa_data, wb_data;
    logic            rs1_busy, rs2_busy, wa_en, wb_en, iss_en, err;
    logic [AW:0]     pend_cnt;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clock_i    (clk),
        .reset_i    (rst),
        .rs1_addr_i (rs1_addr),
        .rs2_addr_i (rs2_addr),
        .rs1_data_o (rs1_data),
        .rs2_data_o (rs2_data),
        .rs1_busy_o (rs1_busy),
        .rs2_busy_o (rs2_busy),
        .wa_en_i    (wa_en),
        .wa_addr_i  (wa_addr),
        .wa_data_i  (wa_data),
        .wb_en_i    (wb_en),
        .wb_addr_i  (wb_addr),
        .wb_data_i  (wb_data),
        .iss_en_i   (iss_en),
        .iss_addr_i (iss_addr),
        .pend_cnt_o (pend_cnt),
        .err_o      (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state as plain arrays.
    logic [31:0] m_regs [NREG];
    bit          m_busy [NREG];
    bit          m_err;

    function automatic logic [31:0] m_read(input int a);
        logic [31:0] v;
        if (a == 0) return 32'h0;
        v = m_regs[a];
        if (BYP && wa_en && int'(wa_addr) == a) v = wa_data;
        if (BYP && wb_en && int'(wb_addr) == a) v = wb_data;
        return v;
    endfunction

    function automatic bit m_busy_rd(input int a);
        if (a == 0) return 1'b0;
        if (BYP && wb_en && int'(wb_addr) == a && !(iss_en && int'(iss_addr) == a))
            return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int m_pending();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic model_clock();
        bit old [NREG];
        int a, b, s;
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                m_regs[i] = (i == 2) ? SP : 32'h0;
                m_busy[i] = 1'b0;
            end
            m_err = 1'b0;
            return;
        end
        old = m_busy;
        a = int'(wa_addr);
        b = int'(wb_addr);
        s = int'(iss_addr);
        if (wa_en && a != 0 && old[a]) m_err = 1'b1;
        if (wa_en && wb_en && a == b && a != 0) m_err = 1'b1;
        if (wb_en && b != 0 && !old[b]) m_err = 1'b1;
        if (iss_en && s != 0 && old[s] && !(wb_en && b == s)) m_err = 1'b1;
        if (wb_en && b != 0) m_busy[b] = 1'b0;
        if (iss_en && s != 0 && (!old[s] || (wb_en && b == s))) m_busy[s] = 1'b1;
        if (wa_en && a != 0) m_regs[a] = wa_data;
        if (wb_en && b != 0) m_regs[b] = wb_data;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".rs1_data"}, rs1_data, m_read(int'(rs1_addr)));
        chk({tag, ".rs2_data"}, rs2_data, m_read(int'(rs2_addr)));
        chk({tag, ".rs1_busy"}, 32'(rs1_busy), 32'(m_busy_rd(int'(rs1_addr))));
        chk({tag, ".rs2_busy"}, 32'(rs2_busy), 32'(m_busy_rd(int'(rs2_addr))));
        chk({tag, ".pend_cnt"}, 32'(pend_cnt), 32'(m_pending()));
        chk({tag, ".err"}, 32'(err), 32'(m_err));
    endtask

    task automatic idle();
        rst = 0; wa_en = 0; wb_en = 0; iss_en = 0;
        wa_addr = '0; wb_addr = '0; iss_addr = '0;
        wa_data = '0; wb_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    typedef struct {
        bit rst, wa_en, wb_en, iss_en;
        logic [AW-1:0] wa_addr, wb_addr, iss_addr, rs1, rs2;
        logic [31:0] wa_data, wb_data, e1, e2;
        bit b1, b2, er;
        int pc;
    } vec_t;

    function automatic vec_t mk(input bit r, input bit wae, input int waa, input logic [31:0] wad,
                                input bit wbe, input int wba, input logic [31:0] wbd,
                                input bit ise, input int isa, input int r1, input int r2,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input bit b1, input bit b2, input int pc, input bit er);
        vec_t v;
        v.rst = r; v.wa_en = wae; v.wa_addr = AW'(waa); v.wa_data = wad;
        v.wb_en = wbe; v.wb_addr = AW'(wba); v.wb_data = wbd;
        v.iss_en = ise; v.iss_addr = AW'(isa); v.rs1 = AW'(r1); v.rs2 = AW'(r2);
        v.e1 = e1; v.e2 = e2; v.b1 = b1; v.b2 = b2; v.pc = pc; v.er = er;
        return v;
    endfunction

    vec_t tbl [18];

    initial begin
        logic [31:0] dbf, x55, xaa;
        dbf = 32'hDEAD_BEEF;
        x55 = 32'h55;
        xaa = 32'hAA;
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 5, SP, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 5, dbf, 0, 0, 0, 0, 0, 5, 5, BYP ? dbf : 0, BYP ? dbf : 0,
                     0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 5, dbf, dbf, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 0, 32'h1234, 1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, SP, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 8, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 8, 7, 8, 0, 0, 1, 0, 1, 0);
        tbl[7]  = mk(0, 0, 0, 0, 1, 7, x55, 0, 0, 7, 8, BYP ? x55 : 0, 0, !BYP, 1, 2, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 8, x55, 0, 0, 1, 1, 0);
        tbl[9]  = mk(0, 1, 9, 1, 1, 9, 2, 0, 0, 9, 8, BYP ? 2 : 0, 0, 0, 1, 1, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 8, 2, 0, 0, 1, 1, 1);
        tbl[11] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 8, 2, 0, 0, 1, 1, 1);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 8, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 10, 10, 10, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 1, 10, xaa, 1, 10, 10, 2, BYP ? xaa : 0, SP, 1, 0, 1, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 2, xaa, SP, 1, 0, 1, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 10, 10, 2, xaa, SP, 1, 0, 1, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 2, xaa, SP, 1, 0, 1, 1);

        idle();
        rs1_addr = '0;
        rs2_addr = '0;
        rst = 1;
        #1;
        tick();
        tick();
        idle();

        // Directed vectors.
        for (int i = 0; i < 18; i++) begin
            string t;
            t = $sformatf("tbl[%0d]", i);
            rst = tbl[i].rst;
            wa_en = tbl[i].wa_en; wa_addr = tbl[i].wa_addr; wa_data = tbl[i].wa_data;
            wb_en = tbl[i].wb_en; wb_addr = tbl[i].wb_addr; wb_data = tbl[i].wb_data;
            iss_en = tbl[i].iss_en; iss_addr = tbl[i].iss_addr;
            rs1_addr = tbl[i].rs1; rs2_addr = tbl[i].rs2;
            #3;
            chk({t, ".rs1_data"}, rs1_data, tbl[i].e1);
            chk({t, ".rs2_data"}, rs2_data, tbl[i].e2);
            chk({t, ".rs1_busy"}, 32'(rs1_busy), 32'(tbl[i].b1));
            chk({t, ".rs2_busy"}, 32'(rs2_busy), 32'(tbl[i].b2));
            chk({t, ".pend_cnt"}, 32'(pend_cnt), 32'(tbl[i].pc));
            chk({t, ".err"}, 32'(err), 32'(tbl[i].er));
            check_model({t, ".model"});
            tick();
        end

        // Fill every non-zero register with a pending load, then drain them all.
        idle();
        rst = 1;
        tick();
        idle();
        for (int r = 1; r < NREG; r++) begin
            iss_en = 1; iss_addr = AW'(r);
            rs1_addr = AW'(r); rs2_addr = AW'(r - 1);
            #3;
            check_model("fill");
            tick();
        end
        idle();
        #3;
        chk("fill.pend_cnt_full", 32'(pend_cnt), NREG - 1);
        for (int r = 1; r < NREG; r++) begin
            wb_en = 1; wb_addr = AW'(r); wb_data = $urandom;
            rs1_addr = AW'(r); rs2_addr = AW'(NREG - r);
            #3;
            check_model("drain");
            tick();
        end
        idle();
        #3;
        chk("drain.pend_cnt_empty", 32'(pend_cnt), 0);
        chk("drain.err", 32'(err), 0);

        // Random traffic, addresses concentrated on a few registers to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 63) == 0);
            wa_en    = $urandom_range(0, 1);
            wa_addr  = AW'($urandom_range(0, 7));
            wa_data  = $urandom;
            wb_en    = ($urandom_range(0, 9) < 4);
            wb_addr  = AW'($urandom_range(0, 7));
            wb_data  = $urandom;
            iss_en   = ($urandom_range(0, 9) < 4);
            iss_addr = AW'($urandom_range(0, 7));
            rs1_addr = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31)
                                                       : $urandom_range(0, 7));
            rs2_addr = AW'($urandom_range(0, 7));
            #3;
            check_model($sformatf("rnd[%0d]", n));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
